// File: rtl/aes_pkg.sv
// Shared AES types and the forward S-box table used by the SubBytes stage.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    typedef logic [AES_BYTE_W-1:0]  aes_byte_t;
    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    // Forward S-box, indexed by input byte value (row = high nibble).
    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box lookup (combinational).
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t i_byte,
    output aes_byte_t o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_sub_bytes.sv
// AES SubBytes over a 128-bit state: 16 independent S-box lanes.
// Macro AES_SUBBYTES_REG_OUT_EN adds a 1-cycle output register; otherwise the path is combinational.
module aes_sub_bytes
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] block,
    output logic [BLOCK_W-1:0] new_block
);

    localparam int NUM_LANES = BLOCK_W / AES_BYTE_W;

    logic [BLOCK_W-1:0] w_sub;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .i_byte (block[g*AES_BYTE_W +: AES_BYTE_W]),
            .o_byte (w_sub[g*AES_BYTE_W +: AES_BYTE_W])
        );
    end

`ifdef AES_SUBBYTES_REG_OUT_EN
    logic [BLOCK_W-1:0] r_new_block;

    // Output register, cleared asynchronously and held at zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_new_block <= {BLOCK_W{1'b0}};
        end else begin
            r_new_block <= w_sub;
        end
    end

    assign new_block = r_new_block;
`else
    logic w_unused_clk;
    assign w_unused_clk = clk;

    // Combinational output gated to zero while reset is asserted.
    always_comb begin
        if (rst) begin
            new_block = {BLOCK_W{1'b0}};
        end else begin
            new_block = w_sub;
        end
    end
`endif

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes; reference S-box is derived from GF(2^8) arithmetic.
module tb_aes_sub_bytes;

`ifdef AES_SUBBYTES_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic         clk;
    logic         rst;
    logic [127:0] block;
    logic [127:0] new_block;

    int checks = 0;
    int errors = 0;

    logic [7:0]   ref_tab [256];
    logic [127:0] exp_q [$];

    aes_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .block     (block),
        .new_block (new_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] c;
        inv = 8'h00;
        for (int v = 1; v < 256; v++) begin
            c = 8'(v);
            if (a != 8'h00 && gmul(a, c) == 8'h01) inv = c;
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = ref_tab[b[i*8 +: 8]];
        return r;
    endfunction

    // Drive one block just after a rising edge; compare the oldest due result at the falling edge.
    task automatic apply(input logic [127:0] blk, input logic [127:0] expv, input string name);
        logic [127:0] e;
        @(posedge clk);
        #1;
        block = blk;
        exp_q.push_back(expv);
        @(negedge clk);
        if (exp_q.size() > LAT) begin
            e = exp_q.pop_front();
            checks++;
            if (new_block !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, new_block, e);
            end
        end
    endtask

    task automatic drain(input string name);
        logic [127:0] e;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (new_block !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, new_block, e);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        block = 128'h00112233445566778899aabbccddeeff;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (new_block !== 128'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", new_block, 128'h0);
        end
        block = {16{8'hff}};
        @(posedge clk);
        #1;
        checks++;
        if (new_block !== 128'h0) begin
            errors++;
            $display("FAIL reset_hold_change: got %h expected %h", new_block, 128'h0);
        end
        block = 128'h00112233445566778899aabbccddeeff;
        rst   = 1'b0;
        exp_q.push_back(128'h638293c31bfc33f5c4eeacea4bc12816);
        drain("reset_release");
    endtask

    task automatic test_constants();
        apply(128'h0, {16{8'h63}}, "all_zero");
        apply({16{8'hff}}, {16{8'h16}}, "all_ones");
        apply(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, "fips_b_round1");
        apply({16{8'h53}}, {16{8'hed}}, "anchor_53");
        apply({16{8'h10}}, {16{8'hca}}, "anchor_10");
        apply({16{8'h01}}, {16{8'h7c}}, "anchor_01");
        drain("constants_drain");
    endtask

    task automatic test_sweep();
        logic [127:0] b;
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) b[i*8 +: 8] = 8'(j*16 + i);
            apply(b, ref_block(b), "sweep");
        end
        drain("sweep_drain");
    endtask

    task automatic test_back_to_back();
        logic [127:0] b;
        for (int n = 0; n < 96; n++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            apply(b, ref_block(b), "back_to_back");
        end
        drain("back_to_back_drain");
    endtask

    task automatic test_mid_reset();
        logic [127:0] b;
        for (int n = 0; n < 4; n++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            apply(b, ref_block(b), "mid_reset_pre");
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (new_block !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got %h expected %h", new_block, 128'h0);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (new_block !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset_hold: got %h expected %h", new_block, 128'h0);
        end
        b     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        block = b;
        rst   = 1'b0;
        exp_q.push_back(128'hd42711aee0bf98f1b8b45de51e415230);
        drain("mid_reset_release");
    endtask

    initial begin
        rst   = 1'b1;
        block = 128'h0;
        for (int v = 0; v < 256; v++) ref_tab[v] = ref_sbox_calc(8'(v));
        test_reset();
        test_constants();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
